// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target block.
package i2c_target_pkg;

  localparam int   I2C_ADDR_W  = 7;
  localparam int   I2C_BYTE_W  = 8;
  localparam logic I2C_RW_READ = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    IGNORE
  } i2c_target_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the clk domain and extracts edge, start and stop events.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl_s;

  // Idle bus level is high, so reset to 1 to avoid phantom edges after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_prev <= w_scl_s;
      r_sda_prev <= sda_s;
    end
  end

  assign w_scl_s   = r_scl_sync[SYNC_STAGES-1];
  assign sda_s     = r_sda_sync[SYNC_STAGES-1];
  assign scl_rise  = w_scl_s & ~r_scl_prev;
  assign scl_fall  = ~w_scl_s & r_scl_prev;
  assign start_det = w_scl_s & r_scl_prev & r_sda_prev & ~sda_s;
  assign stop_det  = w_scl_s & r_scl_prev & ~r_sda_prev & sda_s;

endmodule

// File: rtl/i2c_target.sv
// Single-address I2C target: ACKs its address, strobes written bytes out, serializes read bytes.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h57,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  output logic                  tx_load,
  output logic                  busy
);

  i2c_target_state_e     r_state, w_state_next;
  logic [I2C_BYTE_W-1:0] r_shift, w_shift_next;
  logic [2:0]            r_bit_cnt, w_bit_cnt_next;
  logic                  r_byte_full, w_byte_full_next;
  logic                  r_rw, w_rw_next;
  logic                  r_ack_bit, w_ack_bit_next;
  logic                  r_sda_oe, w_sda_oe_next;
  logic [I2C_BYTE_W-1:0] r_rx_data, w_rx_data_next;
  logic                  r_rx_valid, w_rx_valid_next;
  logic                  r_busy, w_busy_next;
  logic                  w_tx_load;

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s;
  logic w_addr_match;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop),
    .sda_s     (w_sda_s)
  );

  assign w_addr_match = (r_shift[I2C_BYTE_W-1:1] == TARGET_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_byte_full <= 1'b0;
      r_rw        <= 1'b0;
      r_ack_bit   <= 1'b1;
      r_sda_oe    <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift     <= w_shift_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_byte_full <= w_byte_full_next;
      r_rw        <= w_rw_next;
      r_ack_bit   <= w_ack_bit_next;
      r_sda_oe    <= w_sda_oe_next;
      r_rx_data   <= w_rx_data_next;
      r_rx_valid  <= w_rx_valid_next;
      r_busy      <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_start) begin
      w_state_next = ADDR;
    end else if (w_stop) begin
      w_state_next = IDLE;
    end else if (w_scl_fall) begin
      case (r_state)
        ADDR:      if (r_byte_full) w_state_next = w_addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK:  w_state_next = (r_rw == I2C_RW_READ) ? READ : WRITE;
        WRITE:     if (r_byte_full) w_state_next = WRITE_ACK;
        WRITE_ACK: w_state_next = WRITE;
        READ:      if (r_bit_cnt == 3'd7) w_state_next = READ_ACK;
        READ_ACK:  w_state_next = r_ack_bit ? IGNORE : READ;
        default:   w_state_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_shift_next     = r_shift;
    w_bit_cnt_next   = r_bit_cnt;
    w_byte_full_next = r_byte_full;
    w_rw_next        = r_rw;
    w_ack_bit_next   = r_ack_bit;
    w_sda_oe_next    = r_sda_oe;
    w_rx_data_next   = r_rx_data;
    w_rx_valid_next  = 1'b0;
    w_busy_next      = r_busy;
    w_tx_load        = 1'b0;
    // Start/stop abandon any partial byte before it can produce a strobe.
    if (w_start || w_stop) begin
      w_bit_cnt_next   = '0;
      w_byte_full_next = 1'b0;
      w_sda_oe_next    = 1'b0;
      if (w_stop) w_busy_next = 1'b0;
    end else if (w_scl_rise) begin
      if (r_state == ADDR || r_state == WRITE) begin
        w_shift_next   = {r_shift[I2C_BYTE_W-2:0], w_sda_s};
        w_bit_cnt_next = r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) w_byte_full_next = 1'b1;
      end
      if (r_state == READ_ACK) w_ack_bit_next = w_sda_s;
    end else if (w_scl_fall) begin
      case (r_state)
        ADDR: begin
          if (r_byte_full) begin
            w_byte_full_next = 1'b0;
            w_sda_oe_next    = w_addr_match;
            w_busy_next      = w_addr_match;
            w_rw_next        = r_shift[0];
          end
        end
        ADDR_ACK, READ_ACK: begin
          if ((r_state == ADDR_ACK && r_rw == I2C_RW_READ) || (r_state == READ_ACK && !r_ack_bit)) begin
            w_tx_load      = 1'b1;
            w_shift_next   = tx_data;
            w_sda_oe_next  = ~tx_data[I2C_BYTE_W-1];
            w_bit_cnt_next = '0;
          end else begin
            w_sda_oe_next  = 1'b0;
          end
        end
        WRITE: begin
          if (r_byte_full) begin
            w_byte_full_next = 1'b0;
            w_rx_data_next   = r_shift;
            w_rx_valid_next  = 1'b1;
            w_sda_oe_next    = 1'b1;
          end
        end
        READ: begin
          if (r_bit_cnt == 3'd7) begin
            w_sda_oe_next  = 1'b0;
            w_bit_cnt_next = '0;
          end else begin
            w_sda_oe_next  = ~r_shift[I2C_BYTE_W-2];
            w_shift_next   = {r_shift[I2C_BYTE_W-2:0], 1'b0};
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end
        end
        WRITE_ACK, IGNORE: w_sda_oe_next = 1'b0;
        default: ;
      endcase
    end
  end

  assign sda_oe   = r_sda_oe;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_load  = w_tx_load;
  assign busy     = r_busy;

endmodule
